// File: rtl/wifi_at_sequencer_pkg.sv
// Shared definitions for the ESP WiFi AT bring-up sequencer: state encoding,
// response characters and command lengths.
package wifi_at_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        GAP,
        WAIT,
        NEXT,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] CHAR_O  = 8'h4F;
    localparam logic [7:0] CHAR_K  = 8'h4B;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam logic [3:0] CMD0_LEN = 4'd4;
    localparam logic [3:0] CMD1_LEN = 4'd6;
    localparam logic [3:0] CMD2_LEN = 4'd13;

    // Expected byte of the "OK\r\n" acknowledgement at matcher position idx.
    function automatic logic [7:0] ok_char(input logic [1:0] idx);
        case (idx)
            2'd0:    ok_char = CHAR_O;
            2'd1:    ok_char = CHAR_K;
            2'd2:    ok_char = CHAR_CR;
            default: ok_char = CHAR_LF;
        endcase
    endfunction

endpackage

// File: rtl/wifi_at_sequencer_cmd_rom.sv
// Combinational command ROM: returns one byte of the selected AT command and
// flags the final byte of that command.
module wifi_cmd_rom
    import wifi_at_sequencer_pkg::*;
(
    input  logic [1:0] cmd_idx,
    input  logic [3:0] byte_ptr,
    output logic [7:0] cmd_byte,
    output logic       last
);

    // Strings are left-aligned in a 16-byte field so byte_ptr selects by shifting.
    localparam logic [127:0] CMD0 = {"AT\r\n", 96'h0};
    localparam logic [127:0] CMD1 = {"ATE0\r\n", 80'h0};
    localparam logic [127:0] CMD2 = {"AT+CWMODE=1\r\n", 24'h0};

    logic [127:0] str;
    logic [127:0] shifted;
    logic [3:0]   len;

    always_comb begin
        str = CMD2;
        len = CMD2_LEN;
        case (cmd_idx)
            2'd0: begin
                str = CMD0;
                len = CMD0_LEN;
            end
            2'd1: begin
                str = CMD1;
                len = CMD1_LEN;
            end
            default: begin
                str = CMD2;
                len = CMD2_LEN;
            end
        endcase
        shifted  = str << {byte_ptr, 3'b000};
        cmd_byte = shifted[127:120];
        last     = (byte_ptr == (len - 4'd1));
    end

endmodule

// File: rtl/wifi_at_sequencer.sv
// AT bring-up sequencer: streams ROM commands byte-by-byte into the UART
// transmitter, waits for "OK\r\n" from the receiver, retries on timeout.
module wifi_at_sequencer
    import wifi_at_sequencer_pkg::*;
#(
    parameter int BYTE_GAP     = 176,
    parameter int RESP_TIMEOUT = 153600,
    parameter int MAX_RETRY    = 2,
    parameter int NUM_CMDS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] cmd_idx
);

    localparam logic [7:0]  GAP_LOAD  = 8'(BYTE_GAP - 1);
    localparam logic [17:0] TMO_LOAD  = 18'(RESP_TIMEOUT - 1);
    localparam logic [1:0]  RETRY_LIM = 2'(MAX_RETRY);
    localparam logic [1:0]  LAST_CMD  = 2'(NUM_CMDS - 1);

    state_t      state, state_nxt;
    logic [1:0]  cmd_idx_nxt;
    logic [3:0]  byte_ptr, byte_ptr_nxt;
    logic [1:0]  retry, retry_nxt;
    logic [7:0]  gap_cnt, gap_cnt_nxt;
    logic [17:0] tmo_cnt, tmo_cnt_nxt;
    logic [1:0]  mptr, mptr_nxt;
    logic [7:0]  tx_data_nxt;
    logic        last_r, last_nxt;
    logic        match;
    logic [7:0]  rom_byte;
    logic        rom_last;

    wifi_cmd_rom u_rom (
        .cmd_idx  (cmd_idx),
        .byte_ptr (byte_ptr),
        .cmd_byte (rom_byte),
        .last     (rom_last)
    );

    always_comb begin
        state_nxt    = state;
        cmd_idx_nxt  = cmd_idx;
        byte_ptr_nxt = byte_ptr;
        retry_nxt    = retry;
        gap_cnt_nxt  = gap_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        mptr_nxt     = mptr;
        tx_data_nxt  = tx_data;
        last_nxt     = last_r;
        match        = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt    = LOAD;
                    cmd_idx_nxt  = 2'd0;
                    byte_ptr_nxt = 4'd0;
                    retry_nxt    = 2'd0;
                end
            end
            LOAD: begin
                tx_data_nxt = rom_byte;
                last_nxt    = rom_last;
                state_nxt   = STROBE;
            end
            STROBE: begin
                gap_cnt_nxt = GAP_LOAD;
                state_nxt   = GAP;
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    if (last_r) begin
                        mptr_nxt    = 2'd0;
                        tmo_cnt_nxt = TMO_LOAD;
                        state_nxt   = WAIT;
                    end else begin
                        byte_ptr_nxt = byte_ptr + 4'd1;
                        state_nxt    = LOAD;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
            WAIT: begin
                // A stray 'O' may be the start of a fresh "OK", so restart at 1.
                if (rx_done) begin
                    if (rx_data == ok_char(mptr)) begin
                        if (mptr == 2'd3) match = 1'b1;
                        else              mptr_nxt = mptr + 2'd1;
                    end else begin
                        mptr_nxt = (rx_data == CHAR_O) ? 2'd1 : 2'd0;
                    end
                end
                if (match) begin
                    state_nxt = NEXT;
                end else if (tmo_cnt == 18'd0) begin
                    if (retry < RETRY_LIM) begin
                        retry_nxt    = retry + 2'd1;
                        byte_ptr_nxt = 4'd0;
                        state_nxt    = LOAD;
                    end else begin
                        state_nxt = ERROR;
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt - 18'd1;
                end
            end
            NEXT: begin
                if (cmd_idx == LAST_CMD) begin
                    state_nxt = DONE;
                end else begin
                    cmd_idx_nxt  = cmd_idx + 2'd1;
                    byte_ptr_nxt = 4'd0;
                    retry_nxt    = 2'd0;
                    state_nxt    = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so tx_wr is a clean pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd_idx  <= 2'd0;
            byte_ptr <= 4'd0;
            retry    <= 2'd0;
            gap_cnt  <= 8'd0;
            tmo_cnt  <= 18'd0;
            mptr     <= 2'd0;
            last_r   <= 1'b0;
            tx_data  <= 8'd0;
            tx_wr    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_idx  <= cmd_idx_nxt;
            byte_ptr <= byte_ptr_nxt;
            retry    <= retry_nxt;
            gap_cnt  <= gap_cnt_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            mptr     <= mptr_nxt;
            last_r   <= last_nxt;
            tx_data  <= tx_data_nxt;
            tx_wr    <= (state_nxt == STROBE);
            busy     <= (state_nxt inside {LOAD, STROBE, GAP, WAIT, NEXT});
            done     <= (state_nxt == DONE);
            error    <= (state_nxt == ERROR);
        end
    end

endmodule

// File: tb/tb_wifi_at_sequencer.sv
// Bench for wifi_at_sequencer: a byte-stream model of the expected command
// traffic and timing, checked against the DUT on every cycle.
module tb_wifi_at_sequencer;

    localparam int BG  = 176;
    localparam int RT  = 400;
    localparam int MR  = 2;
    localparam int BYTE_PERIOD = BG + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] cmd_idx;

    always #5 clk = ~clk;

    wifi_at_sequencer #(
        .BYTE_GAP     (BG),
        .RESP_TIMEOUT (RT),
        .MAX_RETRY    (MR),
        .NUM_CMDS     (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .cmd_idx (cmd_idx)
    );

    // kind: 0 = no timing check, 1 = fixed spacing from previous strobe,
    // 2 = absolute cycle published by the stimulus (start / final LF).
    typedef struct {
        logic [7:0] b;
        int         kind;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    string      cmds[3];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         n_wr = 0;
    int         last_wr = 0;
    int         next_due = -1;
    int         done_due = -1;
    int         last_rx = 0;
    logic [7:0] last_byte = 8'h00;
    logic       prev_wr = 1'b0;
    bit         mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mon_on) begin
            if (tx_wr) begin
                chk("tx_wr_width", {31'd0, prev_wr}, 0);
                chk("busy_at_strobe", {31'd0, busy}, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_wr", {31'd0, tx_wr}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, e.b});
                    if (e.kind == 1) chk("strobe_spacing", cyc - last_wr, e.gap);
                    if (e.kind == 2) chk("strobe_cycle", cyc, next_due);
                end
                last_wr   = cyc;
                last_byte = tx_data;
                n_wr++;
            end else if (exp_q.size() > 0) begin
                if (exp_q[0].kind == 1 && (cyc - last_wr) == exp_q[0].gap + 1)
                    chk("missing_strobe", {31'd0, tx_wr}, 1);
                if (exp_q[0].kind == 2 && cyc == next_due)
                    chk("missing_strobe_abs", {31'd0, tx_wr}, 1);
            end
            chk("busy_vs_flags", {31'd0, busy & (done | error)}, 0);
        end
        prev_wr = tx_wr;
    end

    task automatic push_cmd(input int k, input int first_kind, input int first_gap);
        for (int i = 0; i < cmds[k].len(); i++) begin
            exp_t x;
            x.b    = cmds[k][i];
            x.kind = (i == 0) ? first_kind : 1;
            x.gap  = (i == 0) ? first_gap : BYTE_PERIOD;
            exp_q.push_back(x);
        end
    endtask

    task automatic pulse_start(input bit set_due);
        @(posedge clk); #1;
        start = 1'b1;
        if (set_due) next_due = cyc + 2;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        last_rx = cyc;
        @(posedge clk); #1;
        rx_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_str(input string s, input bit final_ok);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        if (final_ok) begin
            next_due = last_rx + 3;
            done_due = last_rx + 2;
        end
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k = 0;
        while (n_wr < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("tx_count_reached", {31'd0, (n_wr >= n)}, 1);
    endtask

    task automatic wait_flag(input bit want_err, input int budget, output int at);
        int k = 0;
        at = -1;
        while (k < budget) begin
            @(negedge clk);
            if (want_err ? error : done) begin
                at = cyc;
                break;
            end
            k++;
        end
        chk(want_err ? "error_rise" : "done_rise", {31'd0, (at >= 0)}, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_outputs_zero();
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_tx_wr", {31'd0, tx_wr}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_cmd_idx", {30'd0, cmd_idx}, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int at;
        int k;
        cmds[0] = "AT\r\n";
        cmds[1] = "ATE0\r\n";
        cmds[2] = "AT+CWMODE=1\r\n";
        rst = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 0);

        // Full sequence: GAP echoes on cmd0, ignored start during cmd1
        base = n_wr;
        push_cmd(0, 2, 0);
        push_cmd(1, 2, 0);
        push_cmd(2, 2, 0);
        pulse_start(1);
        wait_wr(base + 4, 2000);
        repeat (10) @(posedge clk);
        #1;
        send_str("OK\r", 0);
        repeat (180) @(posedge clk);
        #1;
        send_str("\nOK\r\n", 1);
        wait_wr(base + 6, 2000);
        pulse_start(0);
        chk("cmd1_idx", {30'd0, cmd_idx}, 1);
        wait_wr(base + 10, 2000);
        repeat (200) @(posedge clk);
        #1;
        send_str("OK\r\n", 1);
        wait_wr(base + 23, 4000);
        repeat (200) @(posedge clk);
        #1;
        send_str("OK\r\n", 1);
        wait_flag(0, 100, at);
        chk("done_cycle", at, done_due);
        chk("done_flag", {31'd0, done}, 1);
        chk("done_busy", {31'd0, busy}, 0);
        chk("done_error", {31'd0, error}, 0);
        chk("done_cmd_idx", {30'd0, cmd_idx}, 2);
        chk("seq_total_bytes", n_wr - base, 23);
        chk("seq_last_byte", {24'd0, last_byte}, 32'h0A);
        chk("seq_queue_empty", exp_q.size(), 0);

        // No response: three attempts of cmd0, then error
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = n_wr;
        push_cmd(0, 2, 0);
        push_cmd(0, 1, BYTE_PERIOD + RT);
        push_cmd(0, 1, BYTE_PERIOD + RT);
        pulse_start(1);
        wait_wr(base + 12, 5000);
        wait_flag(1, RT + 400, at);
        chk("error_cycle", at, last_wr + BG + 1 + RT);
        chk("error_cmd_idx", {30'd0, cmd_idx}, 0);
        chk("error_busy", {31'd0, busy}, 0);
        chk("error_done", {31'd0, done}, 0);
        repeat (500) @(posedge clk);
        #1;
        chk("error_no_more_tx", n_wr - base, 12);
        chk("error_sticky", {31'd0, error}, 1);

        // Restart from ERROR; matcher recovery on "OOK" and "xOK"; "O K" retries
        base = n_wr;
        push_cmd(0, 2, 0);
        push_cmd(1, 2, 0);
        push_cmd(2, 2, 0);
        push_cmd(2, 1, BYTE_PERIOD + RT);
        pulse_start(1);
        @(negedge clk);
        chk("restart_error_clear", {31'd0, error}, 0);
        chk("restart_busy", {31'd0, busy}, 1);
        chk("restart_cmd_idx", {30'd0, cmd_idx}, 0);
        @(posedge clk); #1;
        wait_wr(base + 4, 2000);
        repeat (200) @(posedge clk);
        #1;
        send_str("OOK\r\n", 1);
        wait_wr(base + 10, 3000);
        repeat (200) @(posedge clk);
        #1;
        send_str("xOK\r\n", 1);
        wait_wr(base + 23, 4000);
        chk("cmd2_idx", {30'd0, cmd_idx}, 2);
        repeat (200) @(posedge clk);
        #1;
        send_str("O K\r\n", 0);
        wait_wr(base + 36, 4000);
        repeat (200) @(posedge clk);
        #1;
        send_str("OK\r\n", 1);
        wait_flag(0, 100, at);
        chk("retry_done_cycle", at, done_due);
        chk("retry_total_bytes", n_wr - base, 36);

        // Reset during a STROBE of cmd1
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = n_wr;
        exp_q.delete();
        push_cmd(0, 2, 0);
        begin
            exp_t x;
            x.b = 8'h41; x.kind = 2; x.gap = 0;
            exp_q.push_back(x);
            x.b = 8'h54; x.kind = 1; x.gap = BYTE_PERIOD;
            exp_q.push_back(x);
        end
        pulse_start(1);
        wait_wr(base + 4, 2000);
        repeat (200) @(posedge clk);
        #1;
        send_str("OK\r\n", 1);
        k = 0;
        while (n_wr < base + 6 && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        chk("reached_cmd1_strobe", {31'd0, (n_wr >= base + 6)}, 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk_outputs_zero();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        chk("post_rst_no_tx", n_wr - base, 6);
        chk("post_rst_busy", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
